// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Central hazard sequencer for the five-stage pipeline (IF, IF/DE, DE/EX,
// EX/MEM, MEM/WB). Every cycle it produces the write-enable and flush
// (bubble) controls for the PC and the four pipeline registers.
//
// It resolves three conditions, highest priority first:
//   1. a data-memory wait freezes the whole pipeline;
//   2. a taken branch flushes the three younger stages;
//   3. a load-use hazard holds PC and IF/DE and inserts a bubble in DE/EX.
// A watchdog moves the sequencer to HALT when one memory access has been
// waiting for TIMEOUT consecutive cycles. Saturating counters record stall
// cycles and branch flushes.
//
// Memory handshake: mem_access acts as the request valid and dmem_ready as
// its ready. The access completes on the cycle both are 1. While mem_access
// is 1 and dmem_ready is 0 the access is pending, and the pipeline must not
// advance. mem_access must stay high until the cycle dmem_ready is seen.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   id_rn, id_rm    source registers of the instruction in decode
//   id_uses_rm      decode instruction actually reads id_rm
//   ex_memread      instruction in execute is a load
//   ex_destreg      destination register of the instruction in execute
//   mem_access      memory-stage instruction performs a data access
//   dmem_ready      data memory completes the access this cycle
//   branch_taken    memory stage resolved a taken branch
//   pc_write .. memwb_flush  per-stage write enables and flushes
//   mem_err         sticky watchdog timeout flag
//   stall_cycles    saturating count of stall cycles (pc_write=0, not HALT)
//   flush_events    saturating count of branch flushes

module pipeline_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_destreg,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifde_write,
  output logic             ifde_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  // Register 31 is XZR: a load targeting it never creates a dependency.
  localparam logic [REG_W-1:0] XZR       = REG_W'(31);
  localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // state is kept as a named internal signal so checkers can bind to it.
  state_t      state;
  state_t      state_next;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_next;
  logic        set_err;
  logic        branch_fire;
  logic        stall_inc;

  logic wait_now;
  logic load_use;

  assign wait_now = mem_access & ~dmem_ready;
  assign load_use = ex_memread & (ex_destreg != XZR) &
                    ((ex_destreg == id_rn) | (id_uses_rm & (ex_destreg == id_rm)));

  // Next state and stage controls. Branch and load-use are only looked at
  // when no wait is pending: the upstream registers are frozen during the
  // wait, so the same inputs are re-evaluated on the release cycle.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    set_err       = 1'b0;
    branch_fire   = 1'b0;
    pc_write      = 1'b0;
    ifde_write    = 1'b0;
    ifde_flush    = 1'b0;
    idex_write    = 1'b0;
    idex_flush    = 1'b0;
    exmem_write   = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;

    unique case (state)
      RUN, MEM_WAIT: begin
        if (wait_now) begin
          // Freeze: nothing advances, MEM/WB receives a bubble.
          memwb_flush = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_next    = HALT;
            set_err       = 1'b1;
            wait_cnt_next = wait_cnt;
          end else begin
            state_next    = MEM_WAIT;
            wait_cnt_next = wait_cnt + 16'd1;
          end
        end else begin
          state_next    = RUN;
          wait_cnt_next = '0;
          pc_write      = 1'b1;
          ifde_write    = 1'b1;
          idex_write    = 1'b1;
          exmem_write   = 1'b1;
          if (branch_taken) begin
            // PC loads the target; the three wrong-path stages are zeroed.
            branch_fire = 1'b1;
            ifde_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (load_use) begin
            // Hold fetch and decode one cycle, send a bubble into execute.
            pc_write   = 1'b0;
            ifde_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
      end
      HALT: begin
        memwb_flush = 1'b1;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // A stall cycle is any non-HALT cycle in which the PC does not load.
  assign stall_inc = (state != HALT) & ~pc_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (set_err) begin
        mem_err <= 1'b1;
      end
      if (stall_inc && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (branch_fire && (flush_events != CNT_MAX)) begin
        flush_events <= flush_events + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//
// Drives pipeline_hazard_ctrl with directed scenarios followed by random
// traffic. A reference model computes the expected controls, mem_err and
// counters for each cycle and pushes them into exp_q; a monitor on the
// falling edge pops and compares against the DUT.

module tb_pipeline_hazard_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;
  localparam int EXP_W      = 8 + 1 + 2 * TB_CNT_W;
  localparam int CNT_SAT    = (1 << TB_CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic [4:0]       id_rn = '0;
  logic [4:0]       id_rm = '0;
  logic             id_uses_rm = 1'b0;
  logic             ex_memread = 1'b0;
  logic [4:0]       ex_destreg = '0;
  logic             mem_access = 1'b0;
  logic             dmem_ready = 1'b0;
  logic             branch_taken = 1'b0;
  logic             pc_write;
  logic             ifde_write;
  logic             ifde_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             mem_err;
  logic [TB_CNT_W-1:0] stall_cycles;
  logic [TB_CNT_W-1:0] flush_events;

  pipeline_hazard_ctrl #(
    .REG_W  (5),
    .TIMEOUT(TB_TIMEOUT),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_uses_rm  (id_uses_rm),
    .ex_memread  (ex_memread),
    .ex_destreg  (ex_destreg),
    .mem_access  (mem_access),
    .dmem_ready  (dmem_ready),
    .branch_taken(branch_taken),
    .pc_write    (pc_write),
    .ifde_write  (ifde_write),
    .ifde_flush  (ifde_flush),
    .idex_write  (idex_write),
    .idex_flush  (idex_flush),
    .exmem_write (exmem_write),
    .exmem_flush (exmem_flush),
    .memwb_flush (memwb_flush),
    .mem_err     (mem_err),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  logic [7:0] act_ctrl;
  assign act_ctrl = {pc_write, ifde_write, ifde_flush, idex_write,
                     idex_flush, exmem_write, exmem_flush, memwb_flush};

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      e = exp_q.pop_front();
      check("ctrl", 32'(act_ctrl), 32'(e[EXP_W-1 -: 8]));
      check("mem_err", 32'(mem_err), 32'(e[2*TB_CNT_W]));
      check("stall_cycles", 32'(stall_cycles), 32'(e[2*TB_CNT_W-1 -: TB_CNT_W]));
      check("flush_events", 32'(flush_events), 32'(e[TB_CNT_W-1:0]));
    end
  end

  // ---------------- reference model ----------------
  // Plain rules: halted flag, length of the current wait run, counts as ints.
  bit m_known = 1'b0;
  bit m_halted;
  int m_wait_run;
  bit m_err;
  int m_stall;
  int m_flush;

  task automatic model_cycle();
    bit         wait_now;
    bit         lu;
    bit         br_row;
    logic [7:0] c;
    wait_now = mem_access && !dmem_ready;
    lu = ex_memread && (ex_destreg != 5'd31) &&
         ((ex_destreg == id_rn) || (id_uses_rm && (ex_destreg == id_rm)));
    br_row = 1'b0;
    // bit order: pc_w ifde_w ifde_f idex_w idex_f exmem_w exmem_f memwb_f
    if (m_halted || wait_now) c = 8'b0000_0001;
    else if (branch_taken) begin
      c = 8'b1111_1110;
      br_row = 1'b1;
    end
    else if (lu) c = 8'b0001_1100;
    else c = 8'b1101_0100;

    if (m_known)
      exp_q.push_back({c, m_err, TB_CNT_W'(m_stall), TB_CNT_W'(m_flush)});

    if (reset) begin
      m_known = 1'b1;
      m_halted = 1'b0;
      m_wait_run = 0;
      m_err = 1'b0;
      m_stall = 0;
      m_flush = 0;
    end else if (!m_halted) begin
      if (!c[7] && m_stall < CNT_SAT) m_stall++;
      if (br_row && m_flush < CNT_SAT) m_flush++;
      if (wait_now) begin
        m_wait_run++;
        if (m_wait_run == TB_TIMEOUT) begin
          m_halted = 1'b1;
          m_err = 1'b1;
        end
      end else begin
        m_wait_run = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit exmr, input logic [4:0] dest,
                      input logic [4:0] rn, input logic [4:0] rm, input bit urm,
                      input bit macc, input bit rdy, input bit br);
    @(posedge clk);
    #1;
    reset        = rst;
    ex_memread   = exmr;
    ex_destreg   = dest;
    id_rn        = rn;
    id_rm        = rm;
    id_uses_rm   = urm;
    mem_access   = macc;
    dmem_ready   = rdy;
    branch_taken = br;
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0);
  endtask

  function automatic logic [4:0] rand_reg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    int ready_pct;
    int wait_cycles;
    do_reset();
    idle(2);

    // Load-use on Rn, then released.
    step(0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 1, 0);
    step(0, 0, 5'd3, 5'd3, 5'd0, 0, 0, 1, 0);
    // XZR never hazards; Rm only counts when it is read.
    step(0, 1, 5'd31, 5'd31, 5'd31, 1, 0, 1, 0);
    step(0, 1, 5'd5, 5'd0, 5'd5, 0, 0, 1, 0);
    step(0, 1, 5'd5, 5'd0, 5'd5, 1, 0, 1, 0);
    // Branch beats a simultaneous load-use.
    step(0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 1, 1);
    idle(1);
    do_reset();

    // Memory wait shorter than the watchdog with a pending branch, then release.
    for (int i = 0; i < TB_TIMEOUT - 1; i++) step(0, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0, 1);
    step(0, 1, 5'd3, 5'd3, 5'd0, 0, 1, 1, 1);
    idle(1);
    do_reset();

    // Watchdog: wait held past TIMEOUT, HALT persists after dmem_ready.
    for (int i = 0; i < TB_TIMEOUT + 2; i++) step(0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 5'd3, 5'd3, 5'd0, 0, 1, 1, 1);
    // Recovery.
    do_reset();
    idle(2);

    // Counter saturation under a held load-use.
    for (int i = 0; i < 20; i++) step(0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 1, 0);
    idle(1);
    do_reset();

    // Random traffic with bursts of slow memory and occasional resets.
    ready_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      bit macc;
      bit rdy;
      if (i % 40 == 0) begin
        case ($urandom_range(0, 2))
          0: ready_pct = 15;
          1: ready_pct = 60;
          default: ready_pct = 95;
        endcase
      end
      macc = ($urandom_range(0, 99) < 50);
      rdy = ($urandom_range(0, 99) < ready_pct);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1), rand_reg(),
           rand_reg(), rand_reg(), ($urandom_range(0, 1) == 1), macc, rdy,
           ($urandom_range(0, 99) < 20));
    end

    // Let the monitor drain the queue, bounded.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline: IF, IF/DE, DE/EX, EX/MEM, MEM/WB.
- Drives per-stage write-enable and flush (bubble) controls for the PC and the four pipeline registers.
- Resolves three conditions:
  - load-use data hazards;
  - taken-branch flushes;
  - multi-cycle data-memory waits, with a timeout watchdog that halts the pipeline.
- Keeps saturating performance counters for stall cycles and branch flushes.

Parameters:
- REG_W, 5, register-specifier width.
- TIMEOUT, 64, maximum consecutive data-memory wait cycles before halt (2..65535).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- id_rn  input  REG_W  Rn field of the instruction in decode
- id_rm  input  REG_W  Rm/Rt field of the instruction in decode
- id_uses_rm  input  1  decode instruction reads id_rm
- ex_memread  input  1  MemRead of the instruction in execute (DE/EX output)
- ex_destreg  input  REG_W  destination register of the instruction in execute
- mem_access  input  1  MemRead or MemWrite of the instruction in memory stage (EX/MEM output)
- dmem_ready  input  1  data memory completes the access this cycle
- branch_taken  input  1  resolved taken branch in memory stage
- pc_write  output  1  PC load enable
- ifde_write  output  1  IF/DE enable
- ifde_flush  output  1  IF/DE loads zero
- idex_write  output  1  DE/EX enable
- idex_flush  output  1  DE/EX loads zero (bubble)
- exmem_write  output  1  EX/MEM enable
- exmem_flush  output  1  EX/MEM loads zero
- memwb_flush  output  1  MEM/WB loads zero
- mem_err  output  1  sticky watchdog timeout flag
- stall_cycles  output  CNT_W  count of cycles with pc_write=0 while not HALT
- flush_events  output  CNT_W  count of branch flushes

Behaviour:
- States:
  - RUN
  - MEM_WAIT
  - HALT
- Reset values:
  - state RUN
  - wait_cnt 0
  - mem_err 0
  - stall_cycles 0
  - flush_events 0
  - Outputs are evaluated combinationally from the RUN state after reset.
- Definitions:
  - wait_now = mem_access & ~dmem_ready.
  - load_use = ex_memread & (ex_destreg != 31) & ((ex_destreg == id_rn) | (id_uses_rm & ex_destreg == id_rm)). Register 31 is XZR and never hazards.
- Output priority in RUN/MEM_WAIT, highest first; only the first matching row applies:
  1. wait_now (freeze):
     - all *_write = 0
     - memwb_flush = 1
     - other flushes 0
  2. branch_taken:
     - all writes 1 (PC loads the target)
     - ifde_flush = idex_flush = exmem_flush = 1
  3. load_use:
     - pc_write = 0, ifde_write = 0
     - idex_flush = 1
     - idex_write = exmem_write = 1
  4. Otherwise: all writes 1, all flushes 0.
- HALT outputs:
  - all writes 0, all flushes 0
  - memwb_flush = 1
- Flush wins over write in the receiving register.
- State transitions:
  - RUN or MEM_WAIT: next = wait_now ? MEM_WAIT : RUN.
  - wait_cnt increments each cycle wait_now=1 and clears to 0 when wait_now=0.
  - If wait_now=1 and wait_cnt == TIMEOUT-1: next state HALT and mem_err <= 1. The freeze is held for exactly TIMEOUT cycles before HALT.
  - HALT is absorbing and is left only by reset.
- Control inputs during a memory wait:
  - branch_taken and load_use are ignored while frozen. The upstream registers hold, so both are re-evaluated on the cycle dmem_ready=1.
  - On that cycle the wait releases with zero extra latency: row 2/3/4 applies the same cycle.
- Counters:
  - stall_cycles increments on every cycle with pc_write=0 in RUN/MEM_WAIT.
  - flush_events increments on every cycle row 2 applies.
  - Both saturate at all-ones and do not wrap.
  - Both are frozen in HALT.
- Latency: the hazard outputs are combinational, with the same cycle as their inputs; only state, wait_cnt, mem_err and the counters are registered.
- Reset mid-wait or in HALT: returns to RUN next edge and clears all registered state.

Test Plan:
- Load-use: ex_memread=1, ex_destreg=3, id_rn=3 for one cycle -> pc_write=0, ifde_write=0, idex_flush=1; stall_cycles 0->1; next cycle (ex_memread=0) all writes 1.
- XZR exemption and Rm qualifier: ex_destreg=31, id_rn=31 -> no stall. ex_destreg=5, id_rm=5, id_uses_rm=0 -> no stall; id_uses_rm=1 -> stall.
- Branch flush: branch_taken=1 with simultaneous load_use -> ifde/idex/exmem_flush=1, pc_write=1; flush_events=1; stall_cycles unchanged.
- Memory wait: mem_access=1, dmem_ready=0 for 5 cycles with branch_taken=1 -> freeze outputs and memwb_flush=1 for 5 cycles, stall_cycles=5; on dmem_ready=1 the branch flush appears in that same cycle, flush_events=1.
- Watchdog: TIMEOUT=4, mem_access=1, dmem_ready=0 held -> mem_err=1 after the 4th wait edge; state HALT, all writes 0 even after dmem_ready=1.
- Recovery: reset=1 for one cycle -> mem_err=0, counters 0, RUN outputs restored.
- Saturation: CNT_W=4, hold load_use 20 cycles -> stall_cycles stops at 15.
